ras_driver: RTL and testbench
=============================

# ras_driver

Command front-end for the speculative return address stack (RAS). It turns a decoded instruction/resolution stream into the RAS single-cycle controls: push, pop, branch, close_valid, close_invalid and push data. It also enforces the RAS sequencing limits: post-reset settle, branch-checkpoint depth and a gap after every close. It returns the predicted return address of each RET to the fetch stage.

## Interface
Parameters:
- WIDTH, 32, address/data width; must match the RAS WIDTH.
- MAX_BRANCHES, 128, RAS checkpoint FIFO depth; the driver allows MAX_BRANCHES+1 open branches (current plus FIFO).
- ILEN, 4, return address offset; ras_din = pc + ILEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  command accepted on an edge where in_valid && in_ready.
- in_op  in  3  0 NOP, 1 CALL, 2 RET, 3 CORET (call+ret), 4 BRANCH, 5 RES_OK, 6 RES_BAD; values 7+ are treated as NOP.
- in_pc  in  WIDTH  PC of the CALL/CORET instruction.
- ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid  out  1 each  registered RAS controls.
- ras_din  out  WIDTH  registered push data.
- ras_dout  in  WIDTH  RAS top-of-stack read data.
- ras_empty  in  1  RAS empty flag.
- pred_valid  out  1  prediction strobe.
- pred_addr  out  WIDTH  predicted return address.
- pred_none  out  1  RAS was empty at pop time; pred_addr is not meaningful.
- branch_cnt  out  $clog2(MAX_BRANCHES+2)  open branch count.
- err_resolve  out  1  sticky: a RES_OK/RES_BAD arrived with branch_cnt==0.

## Operation
- States:
  - INIT0 and INIT1 cover the two RAS internal reset cycles.
  - RUN accepts commands.
  - HOLD is a one-cycle gap after any accepted RES_OK/RES_BAD.
- Transitions:
  - rst → INIT0.
  - INIT0 → INIT1 → RUN unconditionally.
  - RUN → HOLD on an accepted RES_OK/RES_BAD.
  - HOLD → RUN unconditionally.
- in_ready = (state==RUN) && !(in_op==BRANCH && branch_cnt==MAX_BRANCHES+1). It is combinational on in_op, so a BRANCH at the limit stalls while other ops pass.
- Accepted op → registered controls in the next cycle, for exactly one cycle:
  - CALL: push=1, din=in_pc+ILEN (modulo 2^WIDTH).
  - RET: pop=1.
  - CORET: push=1 and pop=1, din=in_pc+ILEN.
  - BRANCH: branch=1, branch_cnt+1.
  - RES_OK with cnt>0: close_valid=1, cnt-1.
  - RES_BAD with cnt>0: close_invalid=1, cnt←0.
  - RES_* with cnt==0: no control raised, err_resolve←1, HOLD still taken.
  - NOP or no accept: all controls 0; ras_din holds its last value.
- Prediction: in the cycle where ras_pop=1, the driver samples ras_empty into a register. In the following cycle:
  - pred_valid=1.
  - pred_addr = ras_dout, combinational pass-through; the RAS data read has 1-cycle latency.
  - pred_none = the sampled flag.
- branch_cnt saturates by construction: a BRANCH is never accepted at the limit. It never underflows.

## Timing
- Reset values while rst is high:
  - in_ready=0, all ras_* controls 0, ras_din=0.
  - pred_valid=0, pred_addr follows ras_dout, pred_none=0.
  - branch_cnt=0, err_resolve=0, state INIT0.
- in_ready is first high in the cycle after the second rising edge following rst deassertion.
- Command latency: accept edge N → control high in cycle N..N+1 → pred_valid high in cycle N+1..N+2.
- Throughput: 1 command/cycle, except 1 dead cycle after each RES_*. A close therefore never coincides with the next close, branch or push; this is the RAS two-cycle vector attach.
- rst asserted mid-operation:
  - All controls drop immediately (asynchronous).
  - branch_cnt and err_resolve are cleared.
  - Any pending prediction is discarded: no pred_valid after reset.

## Test plan
- Reset/settle: pulse rst, then hold in_valid=1, op=CALL → in_ready=0 for 2 cycles; first accept on the 3rd edge; ras_push high 1 cycle with ras_din=pc+4.
- CALL pc=0x100, CALL pc=0x200, RET, RET → pred_addr 0x204 then 0x104, pred_none=0; a third RET gives pred_none=1.
- Limit, MAX_BRANCHES=2: 3 BRANCH accepted (branch_cnt=3); 4th BRANCH stalls with in_ready=0 while a concurrent-cycle RET is accepted; after RES_OK, cnt=2 and the stalled BRANCH is accepted.
- BRANCH, CALL, RES_OK, RES_OK back-to-back valid → one HOLD cycle after each RES_OK (in_ready=0); close_valid pulses are ≥2 cycles apart; final cnt=0.
- BRANCH×3 then RES_BAD → close_invalid for 1 cycle, branch_cnt=0; a following RES_OK sets err_resolve=1 and no RAS control toggles.
- CORET pc=0x40 on an empty RAS → push and pop both high in the same cycle, ras_din=0x44, pred_none=1; assert rst mid-stream → outputs zero at once, no pred_valid afterwards.

Source files
------------

// File: rtl/ras_driver_if.sv
// Command stream into the RAS front-end: one decoded instruction/resolution per beat.
interface ras_driver_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_pc;

  modport master (output in_valid, output in_op, output in_pc, input in_ready);
  modport slave  (input in_valid, input in_op, input in_pc, output in_ready);
endinterface

// File: rtl/ras_driver.sv
// RAS command front-end: accepted op -> registered RAS control next cycle, prediction one cycle later.
// Backpressure: in_ready low during settle, for one cycle after each resolve, and for a BRANCH at the checkpoint limit.
module ras_driver #(
  parameter int WIDTH        = 32,
  parameter int MAX_BRANCHES = 128,
  parameter int ILEN         = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  ras_driver_if.slave                           cmd,
  output logic                                  ras_push,
  output logic                                  ras_pop,
  output logic                                  ras_branch,
  output logic                                  ras_close_valid,
  output logic                                  ras_close_invalid,
  output logic [WIDTH-1:0]                      ras_din,
  input  logic [WIDTH-1:0]                      ras_dout,
  input  logic                                  ras_empty,
  output logic                                  pred_valid,
  output logic [WIDTH-1:0]                      pred_addr,
  output logic                                  pred_none,
  output logic [$clog2(MAX_BRANCHES+2)-1:0]     branch_cnt,
  output logic                                  err_resolve
);
  localparam int CW = $clog2(MAX_BRANCHES + 2);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_BRANCHES + 1);

  localparam logic [2:0] OP_CALL   = 3'd1;
  localparam logic [2:0] OP_RET    = 3'd2;
  localparam logic [2:0] OP_CORET  = 3'd3;
  localparam logic [2:0] OP_BRANCH = 3'd4;
  localparam logic [2:0] OP_RESOK  = 3'd5;
  localparam logic [2:0] OP_RESBAD = 3'd6;

  typedef enum logic [1:0] {INIT0, INIT1, RUN, HOLD} state_t;
  state_t state, state_nxt;

  logic ready, accept;
  logic do_push, do_pop, do_branch, do_resok, do_resbad, cnt_zero;

  assign cmd.in_ready = ready;
  assign pred_addr    = ras_dout;
  assign cnt_zero     = (branch_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    case (state)
      INIT0: state_nxt = INIT1;
      INIT1: state_nxt = RUN;
      RUN: begin
        // Only a BRANCH is held back at the limit; other ops keep flowing.
        ready  = !(cmd.in_op == OP_BRANCH && branch_cnt == LIMIT);
        accept = cmd.in_valid && ready;
        if (accept && (cmd.in_op == OP_RESOK || cmd.in_op == OP_RESBAD))
          state_nxt = HOLD;
      end
      HOLD:    state_nxt = RUN;
      default: state_nxt = INIT0;
    endcase
  end

  always_comb begin
    do_push   = accept && (cmd.in_op == OP_CALL || cmd.in_op == OP_CORET);
    do_pop    = accept && (cmd.in_op == OP_RET  || cmd.in_op == OP_CORET);
    do_branch = accept && (cmd.in_op == OP_BRANCH);
    do_resok  = accept && (cmd.in_op == OP_RESOK);
    do_resbad = accept && (cmd.in_op == OP_RESBAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_push          <= 1'b0;
      ras_pop           <= 1'b0;
      ras_branch        <= 1'b0;
      ras_close_valid   <= 1'b0;
      ras_close_invalid <= 1'b0;
      ras_din           <= '0;
      branch_cnt        <= '0;
      err_resolve       <= 1'b0;
      pred_valid        <= 1'b0;
      pred_none         <= 1'b0;
    end else begin
      ras_push          <= do_push;
      ras_pop           <= do_pop;
      ras_branch        <= do_branch;
      ras_close_valid   <= do_resok  && !cnt_zero;
      ras_close_invalid <= do_resbad && !cnt_zero;
      if (do_push) ras_din <= cmd.in_pc + WIDTH'(ILEN);

      if (do_branch)                          branch_cnt <= branch_cnt + CW'(1);
      else if (do_resok && !cnt_zero)         branch_cnt <= branch_cnt - CW'(1);
      else if (do_resbad)                     branch_cnt <= '0;
      if ((do_resok || do_resbad) && cnt_zero) err_resolve <= 1'b1;

      // RAS read data lands one cycle after the pop, alongside pred_valid.
      pred_valid <= ras_pop;
      pred_none  <= ras_pop && ras_empty;
    end
  end
endmodule

// File: tb/tb_ras_driver.sv
// Randomised and directed bench for ras_driver with a behavioural command-level model and a toy RAS.
module tb_ras_driver;
  localparam int W = 32;
  localparam int MAXB = 2;
  localparam int CW = $clog2(MAXB + 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ras_driver_if #(.WIDTH(W)) cmd ();
  logic ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid;
  logic [W-1:0] ras_din, ras_dout, pred_addr;
  logic ras_empty, pred_valid, pred_none, err_resolve;
  logic [CW-1:0] branch_cnt;

  ras_driver #(.WIDTH(W), .MAX_BRANCHES(MAXB), .ILEN(4)) dut (
    .clk(clk), .rst(rst), .cmd(cmd),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_branch(ras_branch),
    .ras_close_valid(ras_close_valid), .ras_close_invalid(ras_close_invalid),
    .ras_din(ras_din), .ras_dout(ras_dout), .ras_empty(ras_empty),
    .pred_valid(pred_valid), .pred_addr(pred_addr), .pred_none(pred_none),
    .branch_cnt(branch_cnt), .err_resolve(err_resolve)
  );

  // Toy RAS: plain stack, registered read data and empty flag; pop before push.
  logic [W-1:0] rstk[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rstk.delete();
      ras_dout  <= '0;
      ras_empty <= 1'b1;
    end else begin
      if (ras_pop) begin
        if (rstk.size() > 0) begin
          ras_dout <= rstk[$];
          rstk.pop_back();
        end else ras_dout <= 32'hDEAD_BEEF;
      end
      if (ras_push) rstk.push_back(ras_din);
      ras_empty <= (rstk.size() == 0);
    end
  end

  int checks = 0;
  int errors = 0;
  int cv_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Command-level model
  logic [W-1:0] mstk[$];
  int   m_cnt, m_settle;
  bit   m_err, m_hold;
  bit   e_push, e_pop, e_br, e_cv, e_ci, e_pv, e_pn, p_v, p_n;
  logic [W-1:0] e_din, e_pa, p_a;

  task automatic model_reset();
    mstk.delete();
    m_cnt = 0; m_settle = 0; m_err = 0; m_hold = 0;
    {e_push, e_pop, e_br, e_cv, e_ci, e_pv, e_pn, p_v, p_n} = '0;
    e_din = '0; e_pa = '0; p_a = '0;
  endtask

  task automatic model_step(input bit acc, input logic [2:0] op, input logic [W-1:0] pc);
    if (m_settle < 2) m_settle++;
    m_hold = 0;
    e_pv = p_v; e_pn = p_n; e_pa = p_a; p_v = 0; p_n = 0;
    {e_push, e_pop, e_br, e_cv, e_ci} = '0;
    if (acc) begin
      if (op == 2 || op == 3) begin
        e_pop = 1; p_v = 1;
        if (mstk.size() == 0) p_n = 1;
        else begin p_a = mstk[$]; mstk.pop_back(); end
      end
      if (op == 1 || op == 3) begin
        e_push = 1; e_din = pc + 4; mstk.push_back(pc + 4);
      end
      if (op == 4) begin e_br = 1; m_cnt++; end
      if (op == 5 || op == 6) begin
        m_hold = 1;
        if (m_cnt == 0) m_err = 1;
        else if (op == 5) begin e_cv = 1; m_cnt--; end
        else begin e_ci = 1; m_cnt = 0; end
      end
    end
  endtask

  logic obs_rdy, obs_push, obs_pop, obs_br, obs_cv, obs_ci, obs_pv, obs_pn, obs_err;
  logic [W-1:0] obs_din, obs_pa;
  logic [CW-1:0] obs_cnt;

  task automatic cycle(input logic v, input logic [2:0] op, input logic [W-1:0] pc);
    bit rdy_m;
    cmd.in_valid = v; cmd.in_op = op; cmd.in_pc = pc;
    @(negedge clk);
    obs_rdy = cmd.in_ready; obs_push = ras_push; obs_pop = ras_pop; obs_br = ras_branch;
    obs_cv = ras_close_valid; obs_ci = ras_close_invalid; obs_din = ras_din;
    obs_pv = pred_valid; obs_pa = pred_addr; obs_pn = pred_none;
    obs_cnt = branch_cnt; obs_err = err_resolve;
    if (obs_cv) cv_seen++;
    rdy_m = (m_settle >= 2) && !m_hold && !(op == 3'd4 && m_cnt == MAXB + 1);
    chk("in_ready", obs_rdy, rdy_m);
    chk("ras_push", obs_push, e_push);
    chk("ras_pop", obs_pop, e_pop);
    chk("ras_branch", obs_br, e_br);
    chk("close_valid", obs_cv, e_cv);
    chk("close_invalid", obs_ci, e_ci);
    chk("ras_din", obs_din, e_din);
    chk("pred_valid", obs_pv, e_pv);
    chk("branch_cnt", obs_cnt, m_cnt);
    chk("err_resolve", obs_err, m_err);
    if (e_pv) chk("pred_none", obs_pn, e_pn);
    if (e_pv && !e_pn) chk("pred_addr", obs_pa, e_pa);
    @(posedge clk); #1;
    model_step(v && rdy_m, op, pc);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, cmd.in_ready, 0);
    chk({tag, "_ctrl"}, {ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid}, 0);
    chk({tag, "_din"}, ras_din, 0);
    chk({tag, "_pred"}, {pred_valid, pred_none}, 0);
    chk({tag, "_cnt"}, branch_cnt, 0);
    chk({tag, "_err"}, err_resolve, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd.in_valid = 0; cmd.in_op = 0; cmd.in_pc = 0;
    #2;
    check_all_zero("rst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic settle();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
  endtask

  initial begin
    // Settle: CALL held valid from reset release, accepted on third edge.
    do_reset();
    cycle(1, 1, 32'h10); chk("settle_rdy_c1", obs_rdy, 0);
    cycle(1, 1, 32'h10); chk("settle_rdy_c2", obs_rdy, 0);
    cycle(1, 1, 32'h10); chk("settle_rdy_c3", obs_rdy, 1);
    cycle(0, 0, 0);      chk("settle_push", obs_push, 1); chk("settle_din", obs_din, 32'h14);
    cycle(0, 0, 0);      chk("settle_push_off", obs_push, 0);

    // CALL/CALL/RET/RET/RET predictions
    do_reset(); settle();
    cycle(1, 1, 32'h100);
    cycle(1, 1, 32'h200);
    cycle(1, 2, 0);
    cycle(1, 2, 0);
    cycle(0, 0, 0);  chk("ret1_pv", obs_pv, 1); chk("ret1_addr", obs_pa, 32'h204); chk("ret1_none", obs_pn, 0);
    cycle(1, 2, 0);  chk("ret2_addr", obs_pa, 32'h104); chk("ret2_none", obs_pn, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);  chk("ret3_pv", obs_pv, 1); chk("ret3_none", obs_pn, 1);

    // Branch limit (MAXB+1 = 3 open)
    do_reset(); settle();
    repeat (3) cycle(1, 4, 0);
    cycle(1, 4, 0);  chk("lim_stall", obs_rdy, 0); chk("lim_cnt3", obs_cnt, 3);
    cycle(1, 2, 0);  chk("lim_ret_ok", obs_rdy, 1);
    cycle(1, 5, 0);  chk("lim_resok_rdy", obs_rdy, 1);
    cycle(1, 4, 0);  chk("lim_hold", obs_rdy, 0); chk("lim_cnt2", obs_cnt, 2);
    cycle(1, 4, 0);  chk("lim_br_accept", obs_rdy, 1);
    cycle(0, 0, 0);  chk("lim_cnt_back", obs_cnt, 3); chk("lim_br_pulse", obs_br, 1);

    // BRANCH, CALL, RES_OK, RES_OK back-to-back
    do_reset(); settle();
    cv_seen = 0;
    cycle(1, 4, 0);
    cycle(1, 1, 32'h300);
    cycle(1, 5, 0);
    cycle(1, 5, 0);  chk("b2b_hold1", obs_rdy, 0); chk("b2b_cv", obs_cv, 1);
    cycle(1, 5, 0);  chk("b2b_rdy", obs_rdy, 1);
    cycle(0, 0, 0);  chk("b2b_hold2", obs_rdy, 0);
    cycle(0, 0, 0);  chk("b2b_cnt", obs_cnt, 0); chk("b2b_err", obs_err, 1);
    chk("b2b_cv_count", cv_seen, 1);

    // RES_BAD collapses all checkpoints; a stray RES_OK flags an error
    do_reset(); settle();
    repeat (3) cycle(1, 4, 0);
    cycle(1, 6, 0);
    cycle(0, 0, 0);  chk("bad_ci", obs_ci, 1); chk("bad_cnt", obs_cnt, 0);
    cycle(1, 5, 0);  chk("bad_resok_rdy", obs_rdy, 1);
    cycle(0, 0, 0);  chk("bad_no_ctrl", {obs_push, obs_pop, obs_br, obs_cv, obs_ci}, 0);
    chk("bad_err", obs_err, 1);

    // CORET on empty RAS, then reset mid-stream
    do_reset(); settle();
    cycle(1, 3, 32'h40);
    cycle(0, 0, 0);  chk("coret_pushpop", {obs_push, obs_pop}, 2'b11); chk("coret_din", obs_din, 32'h44);
    cycle(0, 0, 0);  chk("coret_pv", obs_pv, 1); chk("coret_none", obs_pn, 1);
    cycle(1, 1, 32'h80);
    cycle(1, 2, 0);
    mid_reset();
    cycle(0, 0, 0);  chk("midrst_no_pred", obs_pv, 0);
    cycle(0, 0, 0);  chk("midrst_no_pred2", obs_pv, 0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) mid_reset();
      cycle(($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
